// File: rtl/stack_processor.sv
// stack_processor: 8-bit stack machine with a 256x8 unified program/data
// memory, a host read/write port and a STACK_DEPTH x 8 register stack.
// One complete instruction per clock while haltN=1.
// Optional build macro: HALT_INSN_EN -- opcode F becomes a sticky HALT;
// without it, opcode F is a one-byte NOP.
module stack_processor #(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       haltN,
  input  logic [7:0] direct_read_address,
  output logic [7:0] direct_read_data,
  input  logic [7:0] direct_write_address,
  input  logic [7:0] direct_write_data,
  input  logic       direct_memory_write
);

  localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_PUSHI = 4'h0,
    OP_PUSH  = 4'h1,
    OP_POP   = 4'h2,
    OP_DUP   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_ADD   = 4'h6,
    OP_SUB   = 4'h7,
    OP_XOR   = 4'h8,
    OP_NOT   = 4'h9,
    OP_HALT  = 4'hF
  } opcode_t;

  logic [7:0]     mem_q [256];
  logic [7:0]     stack_q [STACK_DEPTH];
  logic [7:0]     pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;

  logic           run;
  opcode_t        opcode;
  logic [7:0]     pc_inc1;
  logic [7:0]     operand;
  logic [SPW-1:0] sp_m1, sp_m2, pop1_sp, pop2_sp;
  logic [7:0]     t_val, n_val, alu_res;

  logic           stk_we;
  logic [IW-1:0]  stk_widx;
  logic [7:0]     stk_wdata;
  logic           core_we;
  logic [7:0]     core_waddr;
  logic [7:0]     core_wdata;

`ifdef HALT_INSN_EN
  logic halted_q, halted_d;
  assign run = haltN & ~halted_q;
`else
  assign run = haltN;
`endif

  assign direct_read_data = mem_q[direct_read_address];

  assign pc_inc1 = pc_q + 8'd1;
  assign opcode  = opcode_t'(mem_q[pc_q][7:4]);
  assign operand = mem_q[pc_inc1];

  // Empty-stack reads yield 0 and pops saturate at SP=0.
  assign sp_m1   = sp_q - SPW'(1);
  assign sp_m2   = sp_q - SPW'(2);
  assign pop1_sp = (sp_q != '0) ? sp_m1 : '0;
  assign pop2_sp = (sp_q >= SPW'(2)) ? sp_m2 : '0;
  assign t_val   = (sp_q != '0) ? stack_q[sp_m1[IW-1:0]] : '0;
  assign n_val   = (sp_q >= SPW'(2)) ? stack_q[sp_m2[IW-1:0]] : '0;

  // Binary/unary ALU result for the current opcode.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_AND:  alu_res = n_val & t_val;
      OP_OR:   alu_res = n_val | t_val;
      OP_ADD:  alu_res = n_val + t_val;
      OP_SUB:  alu_res = n_val - t_val;
      OP_XOR:  alu_res = n_val ^ t_val;
      OP_NOT:  alu_res = ~t_val;
      default: alu_res = '0;
    endcase
  end

  // Decode/execute: next PC, SP, stack write and core memory write.
  always_comb begin
    pc_d       = pc_q;
    sp_d       = sp_q;
    stk_we     = 1'b0;
    stk_widx   = '0;
    stk_wdata  = '0;
    core_we    = 1'b0;
    core_waddr = operand;
    core_wdata = t_val;
`ifdef HALT_INSN_EN
    halted_d   = halted_q;
`endif
    if (run) begin
      pc_d = pc_inc1;
      case (opcode)
        OP_PUSHI, OP_PUSH: begin
          pc_d = pc_q + 8'd2;
          if (sp_q != SP_FULL) begin
            stk_we    = 1'b1;
            stk_widx  = sp_q[IW-1:0];
            stk_wdata = (opcode == OP_PUSHI) ? operand : mem_q[operand];
            sp_d      = sp_q + SPW'(1);
          end
        end
        OP_POP: begin
          pc_d    = pc_q + 8'd2;
          core_we = 1'b1;
          sp_d    = pop1_sp;
        end
        OP_DUP: begin
          if (sp_q != SP_FULL) begin
            stk_we    = 1'b1;
            stk_widx  = sp_q[IW-1:0];
            stk_wdata = t_val;
            sp_d      = sp_q + SPW'(1);
          end
        end
        // Pop two (saturating) then push the result into the lower slot.
        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR: begin
          stk_we    = 1'b1;
          stk_widx  = pop2_sp[IW-1:0];
          stk_wdata = alu_res;
          sp_d      = pop2_sp + SPW'(1);
        end
        OP_NOT: begin
          stk_we    = 1'b1;
          stk_widx  = pop1_sp[IW-1:0];
          stk_wdata = alu_res;
          sp_d      = pop1_sp + SPW'(1);
        end
        OP_HALT: begin
`ifdef HALT_INSN_EN
          halted_d = 1'b1;
          pc_d     = pc_q;
`endif
        end
        default: ;
      endcase
    end
  end

  // Core state registers: PC, SP, stack and halted flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc_q <= '0;
      sp_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[IW'(i)] <= '0;
`ifdef HALT_INSN_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
      sp_q <= sp_d;
      if (stk_we) stack_q[stk_widx] <= stk_wdata;
`ifdef HALT_INSN_EN
      halted_q <= halted_d;
`endif
    end
  end

  // Unified memory; the host write is applied last so it wins a collision.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < 256; i++) mem_q[8'(i)] <= '0;
    end else begin
      if (core_we) mem_q[core_waddr] <= core_wdata;
      if (direct_memory_write) mem_q[direct_write_address] <= direct_write_data;
    end
  end

endmodule

// File: tb/tb_stack_processor.sv
// Self-checking bench for stack_processor: directed scenarios plus random
// programs checked against an instruction-level reference interpreter.
module tb_stack_processor;

  localparam int unsigned DEPTH = 8;

  logic       clk;
  logic       resetN;
  logic       haltN;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mem_m [256];
  logic [7:0] stk_m [$];
  logic [7:0] pc_m;
  bit         halted_m;

  stack_processor #(.STACK_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .haltN                (haltN),
    .direct_read_address  (rd_addr),
    .direct_read_data     (rd_data),
    .direct_write_address (wr_addr),
    .direct_write_data    (wr_data),
    .direct_memory_write  (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    stk_m.delete();
    pc_m     = 8'h00;
    halted_m = 1'b0;
  endtask

  function automatic logic [7:0] m_pop();
    if (stk_m.size() == 0) return 8'h00;
    return stk_m.pop_back();
  endfunction

  function automatic void m_push(input logic [7:0] v);
    if (stk_m.size() < DEPTH) stk_m.push_back(v);
  endfunction

  task automatic model_step();
    logic [7:0] pc1, opd, t, n;
    logic [3:0] op;
    if (!halted_m) begin
      pc1 = pc_m + 8'd1;
      op  = mem_m[pc_m][7:4];
      opd = mem_m[pc1];
      case (op)
        4'h0: begin m_push(opd);        pc_m = pc_m + 8'd2; end
        4'h1: begin m_push(mem_m[opd]); pc_m = pc_m + 8'd2; end
        4'h2: begin mem_m[opd] = m_pop(); pc_m = pc_m + 8'd2; end
        4'h3: begin
          t = (stk_m.size() != 0) ? stk_m[$] : 8'h00;
          m_push(t);
          pc_m = pc_m + 8'd1;
        end
        4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
          t = m_pop();
          n = m_pop();
          case (op)
            4'h4:    m_push(n & t);
            4'h5:    m_push(n | t);
            4'h6:    m_push(n + t);
            4'h7:    m_push(n - t);
            default: m_push(n ^ t);
          endcase
          pc_m = pc_m + 8'd1;
        end
        4'h9: begin m_push(~m_pop()); pc_m = pc_m + 8'd1; end
`ifdef HALT_INSN_EN
        4'hF: halted_m = 1'b1;
`endif
        default: pc_m = pc_m + 8'd1;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic load(input logic [7:0] prog [$]);
    foreach (prog[i]) host_write(8'(i), prog[i]);
  endtask

  task automatic run(input int n);
    @(negedge clk);
    haltN = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step();
    end
    haltN = 1'b0;
  endtask

  task automatic idle(input int n);
    haltN = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    host_write(8'h10, 8'hA5);
    host_write(8'hFF, 8'h3C);
    do_reset();
    for (int a = 0; a < 256; a++) begin
      read_mem(8'(a), d);
      n_checks++;
      if (d !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mem[%0d]: got %h expected 00", a, d);
      end
    end
  endtask

  task automatic test_host_write();
    logic [7:0] d;
    do_reset();
    host_write(8'd3, 8'h5A);
    read_mem(8'd3, d);
    n_checks++;
    if (d !== 8'h5A) begin
      n_fail++;
      $display("FAIL host_write_a3: got %h expected 5a", d);
    end
    read_mem(8'd4, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL host_write_a4: got %h expected 00", d);
    end
  endtask

  task automatic test_program();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {8'h10, 8'hFF, 8'h00, 8'h17, 8'h60, 8'h20, 8'hFF, 8'h10, 8'hFF,
         8'h10, 8'hFF, 8'h60, 8'h00, 8'h0C, 8'h70, 8'h20, 8'hFF};
    load(p);
    host_write(8'hFF, 8'd17);
    run(4);
    read_mem(8'hFF, d);
    n_checks++;
    if (d !== 8'd40) begin
      n_fail++;
      $display("FAIL program_after4: got %0d expected 40", d);
    end
    run(6);
    read_mem(8'hFF, d);
    n_checks++;
    if (d !== 8'd68) begin
      n_fail++;
      $display("FAIL program_end: got %0d expected 68", d);
    end
    // Next instructions at PC=17: PUSHI 0x55; POP 0x80 -- must wait for haltN.
    host_write(8'd17, 8'h00);
    host_write(8'd18, 8'h55);
    host_write(8'd19, 8'h20);
    host_write(8'd20, 8'h80);
    idle(10);
    read_mem(8'h80, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL program_frozen: got %h expected 00", d);
    end
    run(2);
    read_mem(8'h80, d);
    n_checks++;
    if (d !== 8'h55) begin
      n_fail++;
      $display("FAIL program_resume: got %h expected 55", d);
    end
  endtask

  task automatic test_freeze();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {8'h00, 8'h33, 8'h20, 8'h80};
    load(p);
    idle(20);
    for (int a = 0; a < 256; a++) begin
      read_mem(8'(a), d);
      n_checks++;
      if (d !== mem_m[a]) begin
        n_fail++;
        $display("FAIL freeze_mem[%0d]: got %h expected %h", a, d, mem_m[a]);
      end
    end
    run(1);
    read_mem(8'h80, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL freeze_first_insn: got %h expected 00", d);
    end
    run(1);
    read_mem(8'h80, d);
    n_checks++;
    if (d !== 8'h33) begin
      n_fail++;
      $display("FAIL freeze_pc_held: got %h expected 33", d);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {};
    for (int i = 1; i <= 9; i++) begin
      p.push_back(8'h00);
      p.push_back(8'(i));
    end
    p.push_back(8'h20);
    p.push_back(8'd200);
    load(p);
    run(10);
    read_mem(8'd200, d);
    n_checks++;
    if (d !== 8'd8) begin
      n_fail++;
      $display("FAIL overflow_drop: got %0d expected 8", d);
    end
  endtask

  task automatic test_alu();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {8'h00, 8'h0F, 8'h00, 8'hF0, 8'h50, 8'h90, 8'h20, 8'd100,
         8'h00, 8'h03, 8'h00, 8'h05, 8'h70, 8'h20, 8'd101,
         // ADD with one entry (N=0), then POP twice: second POP is empty
         8'h00, 8'h2B, 8'h60, 8'h20, 8'd102, 8'h20, 8'd103};
    load(p);
    host_write(8'd103, 8'hEE);
    run(13);
    read_mem(8'd100, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL alu_or_not: got %h expected 00", d);
    end
    read_mem(8'd101, d);
    n_checks++;
    if (d !== 8'hFE) begin
      n_fail++;
      $display("FAIL alu_sub: got %h expected fe", d);
    end
    read_mem(8'd102, d);
    n_checks++;
    if (d !== 8'h2B) begin
      n_fail++;
      $display("FAIL alu_single_entry: got %h expected 2b", d);
    end
    read_mem(8'd103, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL pop_empty: got %h expected 00", d);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {8'h00, 8'h11, 8'h20, 8'h90};
    load(p);
    run(1);
    @(negedge clk);
    haltN   = 1'b1;
    wr_addr = 8'h90;
    wr_data = 8'h77;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    haltN = 1'b0;
    wr_en = 1'b0;
    model_step();
    mem_m[8'h90] = 8'h77;
    read_mem(8'h90, d);
    n_checks++;
    if (d !== 8'h77) begin
      n_fail++;
      $display("FAIL collision_host_wins: got %h expected 77", d);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {8'h00, 8'h44, 8'h20, 8'h70};
    load(p);
    run(1);
    @(negedge clk);
    haltN  = 1'b1;
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    haltN  = 1'b0;
    model_reset();
    read_mem(8'h70, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_write_lost: got %h expected 00", d);
    end
    read_mem(8'h01, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_mem_cleared: got %h expected 00", d);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, ha, hd;
    bit         h, w;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int a = 0; a < 256; a++) host_write(8'(a), 8'($urandom));
      for (int c = 0; c < 120; c++) begin
        h  = ($urandom_range(0, 3) != 0);
        w  = ($urandom_range(0, 7) == 0);
        ha = 8'($urandom);
        hd = 8'($urandom);
        @(negedge clk);
        haltN   = h;
        wr_en   = w;
        wr_addr = ha;
        wr_data = hd;
        @(posedge clk);
        #1;
        haltN = 1'b0;
        wr_en = 1'b0;
        if (h) model_step();
        if (w) mem_m[ha] = hd;
      end
      for (int a = 0; a < 256; a++) begin
        read_mem(8'(a), d);
        n_checks++;
        if (d !== mem_m[a]) begin
          n_fail++;
          $display("FAIL random_it%0d_mem[%0d]: got %h expected %h", it, a, d, mem_m[a]);
        end
      end
    end
  endtask

`ifdef HALT_INSN_EN
  task automatic test_halt();
    logic [7:0] d;
    logic [7:0] p [$];
    do_reset();
    p = {8'h00, 8'h01, 8'hF0, 8'h00, 8'h02, 8'h20, 8'd50};
    load(p);
    run(20);
    read_mem(8'd50, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL halt_sticky: got %h expected 00", d);
    end
    host_write(8'd60, 8'hAB);
    read_mem(8'd60, d);
    n_checks++;
    if (d !== 8'hAB) begin
      n_fail++;
      $display("FAIL halt_host_port: got %h expected ab", d);
    end
    do_reset();
    p = {8'h00, 8'h01, 8'hA0, 8'h00, 8'h02, 8'h20, 8'd50};
    load(p);
    run(4);
    read_mem(8'd50, d);
    n_checks++;
    if (d !== 8'h02) begin
      n_fail++;
      $display("FAIL halt_reset_pc0: got %h expected 02", d);
    end
  endtask
`endif

  initial begin
    resetN  = 1'b1;
    haltN   = 1'b0;
    rd_addr = 8'h00;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    wr_en   = 1'b0;
    #2;
    resetN = 1'b0;
    #4;
    resetN = 1'b1;
    model_reset();

    test_reset();
    test_host_write();
    test_program();
    test_freeze();
    test_overflow();
    test_alu();
    test_collision();
    test_reset_midrun();
`ifdef HALT_INSN_EN
    test_halt();
`endif
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
